// File: rtl/fp_mul_pipe_hs.sv
// Pipelined floating-point multiplier with a valid/ready handshake.
// It has three register stages: S1 captures and classifies the operands.
// S2 forms the raw significand product and the exponent sum.
// S3 normalises, rounds to nearest-even and packs the result with its flags.
// Subnormal operands and underflowing results are flushed to signed zero.
module fp_mul_pipe_hs #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   f,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;          // significand width including hidden bit
  localparam int PW = 2 * SW;             // raw product width
  localparam int XW = EXP_W + 2;          // exponent working width (two's complement)
  localparam logic [XW-1:0] BIAS_X   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EXP_ALL1 = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // The whole pipe advances together; it holds only when a result is waiting unaccepted.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = rst && en;

  // ---------------- operand classification ----------------
  logic [W-1:0]     op_word [2];
  logic [EXP_W-1:0] op_exp  [2];
  logic [SW-1:0]    op_sig  [2];
  logic [1:0]       op_sign, op_zero, op_inf, op_nan, op_snan;

  assign op_word[0] = a;
  assign op_word[1] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      logic [MAN_W-1:0] frac;
      logic             exp_ones;
      assign frac          = op_word[gi][MAN_W-1:0];
      assign op_exp[gi]    = op_word[gi][W-2 -: EXP_W];
      assign exp_ones      = &op_exp[gi];
      assign op_sign[gi]   = op_word[gi][W-1];
      // exp=0 covers both true zero and subnormals, which are flushed.
      assign op_zero[gi]   = (op_exp[gi] == '0);
      assign op_inf[gi]    = exp_ones && (frac == '0);
      assign op_nan[gi]    = exp_ones && (frac != '0);
      assign op_snan[gi]   = op_nan[gi] && !frac[MAN_W-1];
      assign op_sig[gi]    = {1'b1, frac};
    end
  endgenerate

  // ---------------- S1 registers ----------------
  logic             s1_valid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s1_sign_reg;
  logic [1:0]       s1_zero_reg, s1_inf_reg, s1_nan_reg, s1_snan_reg;
  logic [EXP_W-1:0] s1_exp_a_reg, s1_exp_b_reg;
  logic [SW-1:0]    s1_sig_a_reg, s1_sig_b_reg;

  // S1: capture operands and their class bits on an input transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_tag_reg   <= in_tag;
      s1_sign_reg  <= op_sign[0] ^ op_sign[1];
      s1_zero_reg  <= op_zero;
      s1_inf_reg   <= op_inf;
      s1_nan_reg   <= op_nan;
      s1_snan_reg  <= op_snan;
      s1_exp_a_reg <= op_exp[0];
      s1_exp_b_reg <= op_exp[1];
      s1_sig_a_reg <= op_sig[0];
      s1_sig_b_reg <= op_sig[1];
    end
  end

  // ---------------- S2: multiply and special-case selection ----------------
  logic            special_next;
  logic [W-1:0]    spec_f_next;
  logic [3:0]      spec_fl_next;
  logic [XW-1:0]   exp_sum_next;
  logic [PW-1:0]   prod_next;

  assign exp_sum_next = {2'b00, s1_exp_a_reg} + {2'b00, s1_exp_b_reg} - BIAS_X;
  assign prod_next    = {{SW{1'b0}}, s1_sig_a_reg} * {{SW{1'b0}}, s1_sig_b_reg};

  // Special results in priority order NaN > inf*0 > inf > zero.
  always_comb begin
    special_next = (|s1_nan_reg) || (|s1_inf_reg) || (|s1_zero_reg);
    spec_f_next  = '0;
    spec_fl_next = 4'b0000;
    if (|s1_nan_reg) begin
      spec_f_next  = QNAN;
      spec_fl_next = {(|s1_snan_reg), 3'b000};
    end else if ((|s1_inf_reg) && (|s1_zero_reg)) begin
      spec_f_next  = QNAN;
      spec_fl_next = 4'b1000;
    end else if (|s1_inf_reg) begin
      spec_f_next  = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      spec_f_next  = {s1_sign_reg, {(W-1){1'b0}}};
    end
  end

  logic             s2_valid_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             s2_sign_reg;
  logic [XW-1:0]    s2_exp_reg;
  logic [PW-1:0]    s2_prod_reg;
  logic             s2_special_reg;
  logic [W-1:0]     s2_spec_f_reg;
  logic [3:0]       s2_spec_fl_reg;

  // S2: register product, exponent sum and any special-case result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
    end else if (en) begin
      s2_valid_reg   <= s1_valid_reg;
      s2_tag_reg     <= s1_tag_reg;
      s2_sign_reg    <= s1_sign_reg;
      s2_exp_reg     <= exp_sum_next;
      s2_prod_reg    <= prod_next;
      s2_special_reg <= special_next;
      s2_spec_f_reg  <= spec_f_next;
      s2_spec_fl_reg <= spec_fl_next;
    end
  end

  // ---------------- S3: normalise, round, range check ----------------
  logic          prod_msb, guard_bit, round_bit, sticky_bit, rnd_up, inexact;
  logic [PW-1:0] norm;
  logic [SW:0]   sig_rnd;
  logic [XW-1:0] exp_fin;
  logic [MAN_W-1:0] frac_fin;
  logic          ovf, unf;

  assign prod_msb   = s2_prod_reg[PW-1];
  // Leading one lands at bit PW-1 after this step.
  assign norm       = prod_msb ? s2_prod_reg : {s2_prod_reg[PW-2:0], 1'b0};
  assign guard_bit  = norm[MAN_W];
  assign round_bit  = norm[MAN_W-1];
  assign sticky_bit = |norm[MAN_W-2:0];
  assign rnd_up     = guard_bit && (round_bit || sticky_bit || norm[MAN_W+1]);
  assign inexact    = guard_bit || round_bit || sticky_bit;
  assign sig_rnd    = {1'b0, norm[PW-1 -: SW]} + {{SW{1'b0}}, rnd_up};
  // A carry out of rounding leaves 10.000..., so the fraction becomes zero.
  assign frac_fin   = sig_rnd[SW] ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];
  assign exp_fin    = s2_exp_reg + {{(XW-1){1'b0}}, prod_msb} + {{(XW-1){1'b0}}, sig_rnd[SW]};
  assign ovf        = !exp_fin[XW-1] && (exp_fin >= EXP_ALL1);
  assign unf        = exp_fin[XW-1] || (exp_fin == '0);

  // S3: output register; bubbles leave f, tag and flags at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      f         <= '0;
      out_tag   <= '0;
      flags     <= 4'b0000;
    end else if (en) begin
      out_valid <= s2_valid_reg;
      if (!s2_valid_reg) begin
        f       <= '0;
        out_tag <= '0;
        flags   <= 4'b0000;
      end else begin
        out_tag <= s2_tag_reg;
        if (s2_special_reg) begin
          f     <= s2_spec_f_reg;
          flags <= s2_spec_fl_reg;
        end else if (ovf) begin
          f     <= {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags <= 4'b0101;
        end else if (unf) begin
          f     <= {s2_sign_reg, {(W-1){1'b0}}};
          flags <= 4'b0011;
        end else begin
          f     <= {s2_sign_reg, exp_fin[EXP_W-1:0], frac_fin};
          flags <= {3'b000, inexact};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe_hs.sv
// Directed testbench for fp_mul_pipe_hs (FP32 defaults) with a result scoreboard.
module tb_fp_mul_pipe_hs;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;
  int rx_count = 0;
  bit saw_low = 0;

  // Expected result travelling with the operands currently driven.
  logic [31:0] exp_f;
  logic [3:0]  exp_tag;
  logic [3:0]  exp_fl;

  typedef struct {
    logic [31:0] f;
    logic [3:0]  tag;
    logic [3:0]  fl;
  } exp_t;
  exp_t sb[$];

  // Vectors: a, b, expected f, expected flags {nv,of,uf,nx}.
  logic [31:0] va  [14] = '{32'h3FC00000, 32'hBFC00000, 32'h3F800001, 32'h7F000000,
                           32'h7F800000, 32'h7F800001, 32'h7FC00000, 32'h00000001,
                           32'h00800000, 32'h3FC00000, 32'h3F800001, 32'h3F800003,
                           32'hC0000000, 32'hFF800000};
  logic [31:0] vb  [14] = '{32'h40000000, 32'h40000000, 32'h3F800001, 32'h7F000000,
                           32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                           32'h3F000000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
                           32'h80000000, 32'h40000000};
  logic [31:0] vf  [14] = '{32'h40400000, 32'hC0400000, 32'h3F800002, 32'h7F800000,
                           32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                           32'h00000000, 32'h40100000, 32'h3FC00002, 32'h3FC00004,
                           32'h00000000, 32'hFF800000};
  logic [3:0]  vfl [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b0101,
                           4'b1000, 4'b1000, 4'b0000, 4'b0000,
                           4'b0011, 4'b0000, 4'b0001, 4'b0001,
                           4'b0000, 4'b0000};

  fp_mul_pipe_hs #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .out_tag   (out_tag),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pushes expectations on input transfers, checks results on output transfers,
  // and checks that a held result does not change while stalled.
  initial begin : monitor
    exp_t e;
    bit hold_pend;
    logic [31:0] hold_f;
    logic [3:0]  hold_tag, hold_fl;
    hold_pend = 0;
    hold_f = '0; hold_tag = '0; hold_fl = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          tests++;
          assert (out_valid === 1'b1 && f === hold_f && out_tag === hold_tag && flags === hold_fl)
          else begin
            fails++;
            $error("FAIL hold_stable: got v=%b f=%h tag=%0d fl=%b, need v=1 f=%h tag=%0d fl=%b",
                   out_valid, f, out_tag, flags, hold_f, hold_tag, hold_fl);
          end
        end
        hold_pend = out_valid && !out_ready;
        hold_f = f; hold_tag = out_tag; hold_fl = flags;
        if (!in_ready) saw_low = 1;
        if (out_valid && out_ready) begin
          tests++;
          if (sb.size() == 0) begin
            assert (out_valid === 1'b0)
            else begin
              fails++;
              $error("FAIL unexpected_out: got f=%h tag=%0d, need no result", f, out_tag);
            end
          end else begin
            e = sb.pop_front();
            rx_count++;
            $display("[TB] out tag=%0d f=%h flags=%b (expect f=%h tag=%0d flags=%b)",
                     out_tag, f, flags, e.f, e.tag, e.fl);
            assert (f === e.f && out_tag === e.tag && flags === e.fl)
            else begin
              fails++;
              $error("FAIL result: got f=%h tag=%0d fl=%b, need f=%h tag=%0d fl=%b",
                     f, out_tag, flags, e.f, e.tag, e.fl);
            end
          end
        end
        if (in_valid && in_ready) begin
          e.f = exp_f; e.tag = exp_tag; e.fl = exp_fl;
          sb.push_back(e);
        end
      end
    end
  end

  // Present vector idx with tag t until accepted; returns just after the accepting edge.
  task automatic send(input int idx, input logic [3:0] t);
    bit ok;
    a = va[idx]; b = vb[idx]; in_tag = t;
    exp_f = vf[idx]; exp_tag = t; exp_fl = vfl[idx];
    in_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    tests++;
    assert (ok == 1'b1)
    else begin
      fails++;
      $error("FAIL send_timeout: got in_ready=%b, need 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been delivered.
  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL drain: got %0d pending results, need 0", sb.size());
    end
  endtask

  initial begin : stim
    int run;
    int seen;
    int rx_before;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    exp_f = '0; exp_tag = '0; exp_fl = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL rst_out_valid: got %b, need 0", out_valid); end
    tests++; assert (f === 32'h0) else begin fails++; $error("FAIL rst_f: got %h, need 0", f); end
    tests++; assert (out_tag === 4'h0) else begin fails++; $error("FAIL rst_tag: got %0d, need 0", out_tag); end
    tests++; assert (flags === 4'h0) else begin fails++; $error("FAIL rst_flags: got %b, need 0", flags); end
    tests++; assert (in_ready === 1'b0) else begin fails++; $error("FAIL rst_in_ready: got %b, need 0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency: result visible exactly 3 cycles after the handshake cycle
    send(0, 4'd5);
    @(negedge clk);
    @(negedge clk);
    tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL latency_early: got out_valid=%b, need 0", out_valid); end
    @(negedge clk);
    tests++; assert (out_valid === 1'b1) else begin fails++; $error("FAIL latency: got out_valid=%b, need 1", out_valid); end
    drain();

    // Back-to-back stream of the remaining vectors: one result per cycle
    @(posedge clk); #1;
    run = 0;
    fork
      begin
        for (int i = 1; i < 14; i++) send(i, 4'(i));
      end
      begin
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 13; k++) begin
          if (out_valid) run++;
          @(negedge clk);
        end
      end
    join
    tests++; assert (run == 13) else begin fails++; $error("FAIL throughput: got %0d valid cycles, need 13", run); end
    drain();

    // Backpressure: six ops while the consumer stalls for five cycles
    @(posedge clk); #1;
    saw_low = 0;
    rx_before = rx_count;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i, 4'(i + 2));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    tests++; assert (saw_low == 1'b1) else begin fails++; $error("FAIL bp_in_ready: got in_ready never low, need low while full"); end
    tests++; assert (rx_count - rx_before == 6) else begin fails++; $error("FAIL bp_count: got %0d results, need 6", rx_count - rx_before); end

    // Reset with two operations in flight
    @(posedge clk); #1;
    send(2, 4'd7);
    send(9, 4'd8);
    rst = 1'b0;
    @(negedge clk);
    tests++; assert (in_ready === 1'b0) else begin fails++; $error("FAIL mid_rst_in_ready: got %b, need 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL mid_rst_out_valid: got %b, need 0", out_valid); end
    tests++; assert (f === 32'h0) else begin fails++; $error("FAIL mid_rst_f: got %h, need 0", f); end
    tests++; assert (flags === 4'h0) else begin fails++; $error("FAIL mid_rst_flags: got %b, need 0", flags); end
    tests++; assert (in_ready === 1'b1) else begin fails++; $error("FAIL mid_rst_in_ready_after: got %b, need 1", in_ready); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++; assert (seen == 0) else begin fails++; $error("FAIL stale_result: got %0d valid cycles, need 0", seen); end

    // Pipe still works after the mid-flight reset
    @(posedge clk); #1;
    rx_before = rx_count;
    send(10, 4'd9);
    drain();
    tests++; assert (rx_count - rx_before == 1) else begin fails++; $error("FAIL post_rst_count: got %0d results, need 1", rx_count - rx_before); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe_hs.md
Name: fp_mul_pipe_hs

Overview:
- Parametrised, IEEE-754-style pipelined floating-point multiplier. It is the successor to the fixed 32-bit three-register multiplier.
- Generalised exponent and mantissa widths.
- Adds a valid/ready handshake with backpressure, a sideband tag, round-to-nearest-even, and special-value handling (zero/inf/NaN/subnormal).
- Sits between an operand-issue stage and a result consumer in the datapath; one result per cycle at full throughput.

Parameters:
- EXP_W, 8, exponent field width (≥3). BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width (≥2). Word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, sideband tag width, carried unchanged alongside its operands.

Ports:
- clk  in  1  Sole clock; all state updates on the rising edge.
- rst  in  1  Reset: synchronous, active-low. One clock; reset is synchronous and active-low.
- in_valid  in  1  Operand pair valid.
- in_ready  out  1  Block accepts operands this cycle.
- a  in  W  Operand A {sign, exp, frac}.
- b  in  W  Operand B.
- in_tag  in  TAG_W  Tag for this operand pair.
- out_valid  out  1  Result valid.
- out_ready  in  1  Consumer accepts result.
- f  out  W  Product.
- out_tag  out  TAG_W  Tag of the product.
- flags  out  4  {nv, of, uf, nx}: invalid, overflow, underflow, inexact.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All stage valid bits, out_valid, f, out_tag and flags clear to 0.
  - in_ready=0 while rst=0.
  - Reset mid-operation discards all in-flight items; no partial result appears.
- Pipeline: 3 registered stages.
  - S1: capture and classify operands.
  - S2: (MAN_W+1)x(MAN_W+1) significand multiply, and exponent sum ea+eb-BIAS in EXP_W+2-bit signed.
  - S3: normalise, round, pack. S3 drives f, out_tag, flags and out_valid.
  - Latency: exactly 3 cycles from the accepting edge to out_valid=1 when unstalled.
- Handshake:
  - en = !out_valid | out_ready.
  - in_ready = en (when rst=1).
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - When en=0 every stage holds, bubbles included, and f/out_tag/flags stay stable while out_valid=1.
  - No drops, no duplicates, strict in-order delivery.
  - Simultaneous out transfer and in transfer in the same cycle is legal and sustains 1 result/cycle.
- Classification:
  - exp=0 is zero; subnormal inputs (exp=0, frac≠0) are flushed to signed zero with no flag.
  - exp=all-ones & frac=0 is inf; exp=all-ones & frac≠0 is NaN.
  - A NaN with frac MSB=0 is sNaN.
- Special results:
  - Priority order: NaN > inf*0 > inf > zero.
  - Any NaN input gives canonical qNaN (sign 0, exp all-ones, frac = 1 followed by zeros). nv=1 only if either input is sNaN.
  - inf*0 gives canonical qNaN with nv=1.
  - inf*finite-nonzero gives inf with sign a^b, no flags.
  - Zero*finite gives signed zero (a^b), no flags.
- Normal path:
  - sign = a^b.
  - The product P is 2*(MAN_W+1) bits. If the MSB is set, shift right 1 and increment the exponent.
  - Round to nearest-even using guard, round, and sticky (OR of all lower bits).
  - nx=1 if any discarded bit is nonzero.
  - A rounding carry out of the significand renormalises with exponent+1.
- Range (checked after rounding):
  - biased exp ≥ all-ones gives inf with sign, of=1, nx=1.
  - biased exp ≤ 0 gives signed zero (flush-to-zero), uf=1, nx=1.
- flags are valid only with out_valid; they are 0 for bubbles.

Test Plan:
- Basic and signed (FP32 defaults): a=0x3FC00000, b=0x40000000, tag=5 → 3 cycles later f=0x40400000, out_tag=5, flags=0. a=0xBFC00000, b=0x40000000 → f=0xC0400000.
- Rounding: 0x3F800001 * 0x3F800001 → f=0x3F800002, flags=nx. 0x7F000000 * 0x7F000000 → f=0x7F800000, flags={of,nx}.
- Specials: 0x7F800000 * 0x00000000 → 0x7FC00000, nv. 0x7F800001 * 0x3F800000 → 0x7FC00000, nv. 0x7FC00000 * 0x3F800000 → 0x7FC00000, flags=0. 0x00000001 * 0x3F800000 → 0x00000000, flags=0.
- Underflow: 0x00800000 * 0x3F000000 → 0x00000000, flags={uf,nx}.
- Backpressure: stream 6 ops on consecutive cycles with out_ready=0 from cycle 2 for 5 cycles → in_ready drops once the pipe is full. Outputs stay stable while held; all 6 results arrive in order with correct tags; then 1/cycle with out_ready=1.
- Reset mid-flight: 2 ops in flight, assert rst=0 for 1 cycle → out_valid=0, f=0, flags=0 next cycle, no stale result emerges later; in_ready=1 the cycle after rst returns to 1.
